// File: rtl/gtxe2_chnl_cpll_lockdet_pkg.sv
// Shared definitions for the GTXE2 channel CPLL lock detector:
// state encoding and the edge-counter width helper.
package gtxe2_chnl_cpll_lockdet_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } lockdet_state_t;

  // Edge counters are one bit wider than the window index so a full window
  // of edges can never wrap.
  function automatic int cnt_w(input int window);
    return $clog2(window) + 1;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_clk_edge_cnt.sv
// Samples an asynchronous monitored clock as data: 2-FF synchronizer,
// rising-edge detect register and a saturating edge counter with a
// synchronous clear. cnt_total already includes the edge presented in the
// current cycle, so the window logic can evaluate it on the window-end cycle
// while the same edge is cleared out of the next window.
module gtxe2_chnl_clk_edge_cnt #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mon_clk,
  output logic [CNT_W-1:0] cnt_total
);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_p2;
  logic             edge_p2;
  logic [CNT_W-1:0] cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic             inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + 1'b1;
    return c;
  endfunction

  assign cnt_total = sat_inc(cnt_q, edge_p2);

  // Synchronize, detect rising edges, and accumulate them per window.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      edge_p2 <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // stage p0/p1: metastability synchronizer
      sync_p0 <= mon_clk;
      sync_p1 <= sync_p0;
      // stage p2: edge detect against the previous synchronized level
      sync_p2 <= sync_p1;
      edge_p2 <= sync_p1 & ~sync_p2;
      // counter stage
      cnt_q   <= clr ? '0 : cnt_total;
    end
  end

endmodule

// File: rtl/gtxe2_chnl_cpll_lockdet.sv
// GTXE2 channel CPLL lock detector. Counts reference and feedback clock
// edges over fixed windows of CPLLLOCKDETCLK cycles and derives CPLLLOCK,
// CPLLREFCLKLOST and CPLLFBCLKLOST from the per-window counts.
// Optional build macro GTXE2_CPLL_LOCK_HYST_EN: lock survives a single
// mismatch window and only drops after two in a row.
module gtxe2_chnl_cpll_lockdet
  import gtxe2_chnl_cpll_lockdet_pkg::*;
#(
  parameter int WINDOW       = 256,
  parameter int TOL          = 2,
  parameter int LOCK_WINDOWS = 4
) (
  input  logic                       CPLLLOCKDETCLK,
  input  logic                       CPLLRESET,
  input  logic                       CPLLPD,
  input  logic                       CPLLLOCKEN,
  input  logic                       ref_clk,
  input  logic                       fb_clk,
  output logic                       CPLLLOCK,
  output logic                       CPLLREFCLKLOST,
  output logic                       CPLLFBCLKLOST,
  output logic [cnt_w(WINDOW)-1:0]   freq_delta
);

  localparam int CNT_W  = cnt_w(WINDOW);
  localparam int WIN_W  = $clog2(WINDOW);
  localparam int GOOD_W = $clog2(LOCK_WINDOWS + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_WINDOWS);
  localparam logic [CNT_W-1:0]  TOL_C    = CNT_W'(TOL);

  lockdet_state_t    state;
  logic [WIN_W-1:0]  win_cnt;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_inc;
  logic [CNT_W-1:0]  ref_cnt;
  logic [CNT_W-1:0]  fb_cnt;
  logic [CNT_W-1:0]  delta;
  logic              rst_all;
  logic              win_end;
  logic              cnt_clr;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
  logic              miss;
`endif

  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  assign rst_all  = CPLLRESET | CPLLPD;
  assign win_end  = (state != ST_IDLE) && (win_cnt == WIN_LAST);
  // Counters stay empty in IDLE so the first window starts clean.
  assign cnt_clr  = (state == ST_IDLE) || win_end;
  assign delta    = abs_diff(ref_cnt, fb_cnt);
  assign good_inc = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;

  gtxe2_chnl_clk_edge_cnt #(.CNT_W(CNT_W)) u_ref_cnt (
    .clk       (CPLLLOCKDETCLK),
    .rst       (rst_all),
    .clr       (cnt_clr),
    .mon_clk   (ref_clk),
    .cnt_total (ref_cnt)
  );

  gtxe2_chnl_clk_edge_cnt #(.CNT_W(CNT_W)) u_fb_cnt (
    .clk       (CPLLLOCKDETCLK),
    .rst       (rst_all),
    .clr       (cnt_clr),
    .mon_clk   (fb_clk),
    .cnt_total (fb_cnt)
  );

  // Window sequencing, per-window evaluation and registered status outputs.
  always_ff @(posedge CPLLLOCKDETCLK) begin
    if (rst_all) begin
      state          <= ST_IDLE;
      win_cnt        <= '0;
      good_cnt       <= '0;
      CPLLLOCK       <= 1'b0;
      CPLLREFCLKLOST <= 1'b0;
      CPLLFBCLKLOST  <= 1'b0;
      freq_delta     <= '0;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
      miss           <= 1'b0;
`endif
    end else begin
      CPLLLOCK <= (state == ST_LOCKED) & CPLLLOCKEN;
      case (state)
        ST_IDLE: begin
          state   <= ST_MEASURE;
          win_cnt <= '0;
        end
        default: begin
          win_cnt <= win_end ? '0 : win_cnt + 1'b1;
          if (win_end) begin
            freq_delta <= delta;
            if (ref_cnt == '0) begin
              CPLLREFCLKLOST <= 1'b1;
              CPLLFBCLKLOST  <= 1'b0;
              good_cnt       <= '0;
              state          <= ST_MEASURE;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
              miss           <= 1'b0;
`endif
            end else if (fb_cnt == '0) begin
              CPLLREFCLKLOST <= 1'b0;
              CPLLFBCLKLOST  <= 1'b1;
              good_cnt       <= '0;
              state          <= ST_MEASURE;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
              miss           <= 1'b0;
`endif
            end else if (delta <= TOL_C) begin
              CPLLREFCLKLOST <= 1'b0;
              CPLLFBCLKLOST  <= 1'b0;
              good_cnt       <= good_inc;
              if (good_inc == GOOD_MAX)
                state <= ST_LOCKED;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
              miss           <= 1'b0;
`endif
            end else begin
              CPLLREFCLKLOST <= 1'b0;
              CPLLFBCLKLOST  <= 1'b0;
              good_cnt       <= '0;
`ifdef GTXE2_CPLL_LOCK_HYST_EN
              // First mismatch while locked only arms the miss flag.
              if ((state == ST_LOCKED) && !miss) begin
                miss <= 1'b1;
              end else begin
                miss  <= 1'b0;
                state <= ST_MEASURE;
              end
`else
              state <= ST_MEASURE;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
